// File: rtl/kernel_exec_timer.sv
// Kernel execution timer: measures how long the synchronized kernel-active level
// stays high plus a fixed writeback tail, and reports it together with the test exit code.
module kernel_exec_timer #(
    parameter int CNT_W       = 32,
    parameter int WB_LATENCY  = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             trig_i,
    input  logic             clear_i,
    input  logic             exit_valid_i,
    input  logic [31:0]      exit_value_i,
    output logic             rpt_valid_o,
    input  logic             rpt_ready_i,
    output logic [CNT_W-1:0] rpt_cycles_o,
    output logic [7:0]       rpt_count_o,
    output logic             rpt_multi_o,
    output logic             rpt_ovf_o,
    output logic [31:0]      rpt_exit_value_o,
    output logic             busy_o,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_TAIL   = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       WB_LAT  = 4'(WB_LATENCY);

    // ------------------------------------------------------------------
    // trig_i synchronizer; trig_p is kept with the synchronizer so that a
    // clear never manufactures a false rise while the kernel is running.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_s;
    logic                   trig_p;
    logic                   rise;
    logic                   fall;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            trig_p <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_i};
            trig_p <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_s = sync_q[SYNC_STAGES-1];
    assign rise   = trig_s & ~trig_p;
    assign fall   = ~trig_s & trig_p;

    // ------------------------------------------------------------------
    // Measurement state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [3:0]         tail_q, tail_d;
    logic [CNT_W-1:0]   last_q, last_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        exit_val_q, exit_val_d;
    logic               pend_q, pend_d;
    logic               commit;
    logic [CNT_W-1:0]   commit_val;

    assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tail_q     <= '0;
            last_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            exit_val_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tail_q     <= tail_d;
            last_q     <= last_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            exit_val_q <= exit_val_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tail_d     = tail_q;
        last_d     = last_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        exit_val_d = exit_val_q;
        pend_d     = pend_q;
        commit     = 1'b0;
        commit_val = cnt_q;

        // Exit strobes are captured in every state but REPORT; the last one wins.
        if (exit_valid_i && (state_q != S_REPORT)) begin
            exit_val_d = exit_value_i;
            pend_d     = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_RUN;
                end else if (pend_q) begin
                    state_d = S_REPORT;
                end
            end

            S_RUN: begin
                if (fall) begin
                    if (WB_LAT == 4'd0) begin
                        commit     = 1'b1;
                        commit_val = cnt_q;
                        state_d    = S_IDLE;
                    end else begin
                        tail_d  = WB_LAT;
                        state_d = S_TAIL;
                    end
                end else if (trig_s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end
                end
            end

            S_TAIL: begin
                // A new kernel launch cuts the tail short and starts a fresh run.
                if (rise) begin
                    commit     = 1'b1;
                    commit_val = cnt_q;
                    cnt_d      = CNT_ONE;
                    state_d    = S_RUN;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        ovf_d = 1'b1;
                    end
                    if (tail_q == 4'd1) begin
                        commit     = 1'b1;
                        commit_val = cnt_inc;
                        state_d    = S_IDLE;
                    end else begin
                        tail_d = tail_q - 4'd1;
                    end
                end
            end

            S_REPORT: begin
                // Report handshake: rpt_valid_o is a pure function of the state
                // register and holds every rpt_* output until rpt_ready_i is seen
                // high; the transfer happens on the edge where both are high.
                if (rpt_ready_i) begin
                    state_d    = S_IDLE;
                    pend_d     = 1'b0;
                    last_d     = '0;
                    count_d    = '0;
                    ovf_d      = 1'b0;
                    exit_val_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            last_d  = commit_val;
            count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
        end

        if (clear_i) begin
            state_d    = S_IDLE;
            cnt_d      = '0;
            tail_d     = '0;
            last_d     = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            exit_val_d = '0;
            pend_d     = 1'b0;
        end
    end

    assign rpt_valid_o      = (state_q == S_REPORT);
    assign rpt_cycles_o     = last_q;
    assign rpt_count_o      = count_q;
    assign rpt_multi_o      = (count_q > 8'd1);
    assign rpt_ovf_o        = ovf_q;
    assign rpt_exit_value_o = exit_val_q;
    assign busy_o           = (state_q == S_RUN) || (state_q == S_TAIL);
    assign dbg_state_o      = state_q;

endmodule

// File: doc/kernel_exec_timer.md
KERNEL_EXEC_TIMER -- requirements
Module: kernel_exec_timer

Interface
REQ-001 Parameter CNT_W, default 32: width of the cycle counter and of rpt_cycles_o.
REQ-002 Parameter WB_LATENCY, default 5: writeback cycles appended to each execution; legal range 0..15.
REQ-003 Parameter SYNC_STAGES, default 2: flip-flop stages in the trig_i synchronizer; minimum 2.
REQ-004 sys_clk  in  1  system clock; all state on rising edge.
REQ-005 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 trig_i  in  1  kernel-active level, asynchronous to sys_clk; high while the kernel runs.
REQ-007 clear_i  in  1  synchronous clear of all measurement state.
REQ-008 exit_valid_i  in  1  single-cycle test-exit strobe.
REQ-009 exit_value_i  in  32  exit code, qualified by exit_valid_i.
REQ-010 rpt_valid_o  out  1  report available.
REQ-011 rpt_ready_i  in  1  report consumer ready.
REQ-012 rpt_cycles_o  out  CNT_W  cycles of the last completed execution, including WB_LATENCY.
REQ-013 rpt_count_o  out  8  completed executions since the last clear or handshake, saturating at 255.
REQ-014 rpt_multi_o  out  1  high when rpt_count_o > 1, meaning the measurement is not representative.
REQ-015 rpt_ovf_o  out  1  sticky flag, set when the cycle counter saturated.
REQ-016 rpt_exit_value_o  out  32  captured exit code.
REQ-017 busy_o  out  1  high in RUN or TAIL.

Function
REQ-018 trig_i SHALL pass through SYNC_STAGES flops to form trig_s; a one-flop delayed copy trig_p SHALL be kept.
REQ-019 A rise is defined as trig_s & ~trig_p; a fall is defined as ~trig_s & trig_p.
REQ-020 The FSM SHALL have four states: IDLE, RUN, TAIL, REPORT.
REQ-021 IDLE: a rise SHALL load cnt=1 and enter RUN.
REQ-022 IDLE: if exit is pending and there is no rise, the FSM SHALL enter REPORT; if both occur together, the rise wins.
REQ-023 RUN: cnt SHALL increment every cycle while trig_s=1.
REQ-024 RUN: a fall SHALL load tail_cnt=WB_LATENCY and enter TAIL; if WB_LATENCY=0 it SHALL instead commit and go to IDLE.
REQ-025 TAIL: cnt SHALL increment and tail_cnt SHALL decrement each cycle; when tail_cnt reaches 1, the block SHALL commit and enter IDLE.
REQ-026 Commit SHALL do all of the following: last_cycles<=cnt (value after the increment in that cycle); rpt_count+=1, saturating at 255.
REQ-027 A rise in TAIL SHALL commit immediately with the current cnt, reload cnt=1 and enter RUN.
REQ-028 Net result: trig_s high for N cycles yields rpt_cycles_o = N + WB_LATENCY.
REQ-029 cnt SHALL saturate at 2^CNT_W-1; reaching saturation SHALL set rpt_ovf_o, which stays set until clear, handshake or reset.
REQ-030 exit_valid_i in any state other than REPORT SHALL capture exit_value_i and set exit_pending.
REQ-031 A later exit_valid_i before the report SHALL overwrite the captured value; exit_valid_i in REPORT SHALL be ignored.
REQ-032 An exit during RUN or TAIL SHALL be deferred: REPORT is entered only after the execution commits and the FSM is in IDLE.
REQ-033 REPORT: rpt_valid_o=1, and all rpt_* outputs SHALL be held stable until rpt_ready_i=1.
REQ-034 The handshake (rpt_valid_o & rpt_ready_i) SHALL clear exit_pending, last_cycles, rpt_count, rpt_ovf_o and rpt_exit_value_o, and return to IDLE the next cycle.
REQ-035 rpt_ready_i SHALL have no effect outside REPORT; rpt_valid_o SHALL NOT depend combinationally on rpt_ready_i.
REQ-036 clear_i SHALL force IDLE and zero all state except the synchronizer flops; it has priority over all events except reset.
REQ-037 rpt_multi_o SHALL be decoded combinationally from rpt_count_o.

Reset
REQ-038 On sys_rst_n=0, all state SHALL reset asynchronously: synchronizer flops 0, FSM IDLE, all counters 0, all outputs 0.
REQ-039 Reset asserted mid-RUN or mid-REPORT SHALL discard the measurement; no report SHALL follow reset release.
REQ-040 A trig_i already high at reset release SHALL be seen as a rise after SYNC_STAGES+1 cycles.

Verification (CNT_W=32, WB_LATENCY=5, SYNC_STAGES=2 unless noted)
REQ-041 trig high 100 cycles, then exit_value=0 -> rpt_valid_o=1, cycles=105, count=1, multi=0, ovf=0, exit_value=0.
REQ-042 two executions of 10 and 20 cycles separated by 50 idle cycles, then exit=3 -> cycles=25, count=2, multi=1, exit_value=3.
REQ-043 exit strobe at cycle 40 of a 100-cycle run -> rpt_valid_o rises only after TAIL ends, cycles=105.
REQ-044 rpt_ready_i low for 7 cycles during REPORT -> all rpt_* outputs stable; on handshake, outputs clear and count=0.
REQ-045 CNT_W=8, trig high 300 cycles -> cycles=255, ovf=1; second case: rise 2 cycles into TAIL -> first execution commits 12 for a 10-cycle trig pulse.
REQ-046 sys_rst_n pulsed low mid-RUN -> all outputs 0 immediately, no report afterwards without a new exit.
